gate_exerciser: RTL
===================

Name: gate_exerciser

Overview:
- Synthesizable stimulus/response checker. It is the driving end of a gate-under-test (GUT), e.g. a NOT gate built from a NAND.
- Sweeps every input combination onto the GUT inputs, waits a settle interval, samples the GUT output and compares it with a selected reference function.
- Reports pass/fail, mismatch count and the first failing vector.
- Sits beside lab gate modules in place of an unsynthesizable `initial`-block bench.

Parameters:
- N_IN, 2, number of GUT inputs driven; legal range 1..8.
- SETTLE_CYC, 4, clock cycles each vector is held before sampling; minimum 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- fn_sel  input  2  reference function: 00 NOT(stim[0]), 01 NAND of all stim bits, 10 NOR of all bits, 11 XOR of all bits.
- resp  input  1  GUT output.
- stim  output  N_IN  vector driven to GUT inputs.
- busy  output  1  high from start acceptance until DONE.
- done  output  1  one-cycle pulse at sweep end.
- pass  output  1  high when the last sweep had zero mismatches; held until next start.
- err_cnt  output  N_IN+1  mismatch count of current/last sweep; max 2^N_IN, no wrap possible.
- first_fail  output  N_IN  stim value of first mismatch; 0 if none.

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters 0. Reset mid-sweep aborts immediately; the next start restarts from stim=0.
- All outputs are registered.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - On start=1 at an edge: stim<=0, err_cnt<=0, first_fail<=0, pass<=0, busy<=1.
  - Latch fn_sel internally; settle_cnt<=SETTLE_CYC-1; go to SETTLE.
- SETTLE:
  - settle_cnt==0 -> CHECK.
  - Otherwise settle_cnt decrements.
  - Each vector is therefore held exactly SETTLE_CYC cycles before its check.
- CHECK (1 cycle):
  - exp = reference(latched fn, stim).
  - If resp!=exp: err_cnt<=err_cnt+1, and if err_cnt==0, first_fail<=stim.
  - If stim is all ones -> DONE.
  - Otherwise stim<=stim+1, settle_cnt reloaded, go to SETTLE.
- DONE (1 cycle):
  - done=1, busy<=0.
  - pass=1 iff err_cnt==0, where err_cnt includes the final CHECK.
  - Go to IDLE.
- Latency: done is high 2^N_IN*(SETTLE_CYC+1) edges after the edge that accepted start.
- start while busy or in DONE: ignored.
- fn_sel changes mid-sweep: ignored; the value latched at start is used.
- N_IN=1: NOT and NAND give identical expectations.
- stim holds its final value (all ones) after DONE until the next start.

Optional Feature:
- Macro: GATE_EXERCISER_RESP_SYNC_EN.
- When defined:
  - resp passes through a 2-flop synchronizer (reset to 0) before comparison.
  - The settle interval becomes SETTLE_CYC+2, so total latency is 2^N_IN*(SETTLE_CYC+3).
- When undefined: resp is compared directly, with the latency given above.

Decomposition:
- Package gate_exerciser_pkg:
  - state enum {IDLE, SETTLE, CHECK, DONE}.
  - fn_sel enum {FN_NOT, FN_NAND, FN_NOR, FN_XOR}.
  - Function ref_out(fn, vec) returning the expected bit.
- One natural sub-module, resp_sync: 2-flop synchronizer, instantiated only under the macro.

Test Plan:
- Pass case: N_IN=2, SETTLE_CYC=4, fn NAND, resp from ideal NAND (#1 delay) -> done at 20 cycles, pass=1, err_cnt=0, first_fail=0.
- NOT from NAND: N_IN=1, fn NOT, resp from NAND with both inputs tied to stim[0] -> done at 10 cycles, pass=1.
- Stuck-at-0: N_IN=2, fn NAND, resp=0 -> err_cnt=3, first_fail=0, pass=0.
- Wrong function: N_IN=2, fn NAND, resp=AND of stim -> err_cnt=4, first_fail=0, pass=0.
- Reset mid-sweep: rst pulsed during SETTLE of stim=2 -> all outputs 0 asynchronously; a new start sweeps from stim=0 and yields the full correct result.
- Ignored inputs: start re-pulsed while busy and fn_sel flipped to XOR mid-sweep -> result identical to test 1. With GATE_EXERCISER_RESP_SYNC_EN defined, done at 28 cycles.

Source files
------------

// File: rtl/gate_exerciser_pkg.sv
// Shared types and the reference-function helper for gate_exerciser.
package gate_exerciser_pkg;

    localparam int unsigned N_IN_MAX = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FN_NOT  = 2'b00,
        FN_NAND = 2'b01,
        FN_NOR  = 2'b10,
        FN_XOR  = 2'b11
    } fn_t;

    // Only the low n bits of vec take part; NOT looks at bit 0 alone.
    function automatic logic ref_out(input fn_t fn, input logic [N_IN_MAX-1:0] vec,
                                     input int unsigned n);
        logic [N_IN_MAX-1:0] mask;
        logic [N_IN_MAX-1:0] used;
        logic                r;
        mask = N_IN_MAX'((9'd1 << n) - 9'd1);
        used = vec & mask;
        unique case (fn)
            FN_NOT:  r = ~vec[0];
            FN_NAND: r = (used != mask);
            FN_NOR:  r = (used == '0);
            FN_XOR:  r = ^used;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_exerciser_resp_sync.sv
// Two-flop synchronizer for the GUT response; used only when
// GATE_EXERCISER_RESP_SYNC_EN is defined.
module gate_exerciser_resp_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/gate_exerciser.sv
// Sweeps all input vectors onto a gate-under-test and checks its response.
// Optional macro GATE_EXERCISER_RESP_SYNC_EN synchronizes resp and stretches the settle time.
module gate_exerciser
    import gate_exerciser_pkg::*;
#(
    parameter int unsigned N_IN       = 2,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      fn_sel,
    input  logic            resp,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] first_fail
);

`ifdef GATE_EXERCISER_RESP_SYNC_EN
    localparam int unsigned SETTLE_TOT = SETTLE_CYC + 2;
`else
    localparam int unsigned SETTLE_TOT = SETTLE_CYC;
`endif
    localparam int unsigned CW = $clog2(SETTLE_CYC + 3);
    localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE_TOT - 1);
    localparam logic [CW-1:0]   CNT_ONE     = CW'(1);
    localparam logic [N_IN-1:0] STIM_ONE    = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE     = (N_IN + 1)'(1);

    state_t            state_q;
    fn_t               fn_q;
    logic [CW-1:0]     settle_q;
    logic [N_IN-1:0]   stim_q;
    logic [N_IN:0]     err_cnt_q;
    logic [N_IN:0]     err_cnt_d;
    logic [N_IN-1:0]   first_fail_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic              resp_s;
    logic              exp_bit;
    logic              mismatch;

`ifdef GATE_EXERCISER_RESP_SYNC_EN
    gate_exerciser_resp_sync u_resp_sync (
        .clk (clk),
        .rst (rst),
        .d_i (resp),
        .q_o (resp_s)
    );
`else
    assign resp_s = resp;
`endif

    always_comb begin
        exp_bit   = ref_out(fn_q, N_IN_MAX'(stim_q), N_IN);
        mismatch  = (resp_s != exp_bit);
        err_cnt_d = mismatch ? (err_cnt_q + ERR_ONE) : err_cnt_q;
    end

    // err_cnt_d is used for pass so the final vector's result is included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            fn_q         <= FN_NOT;
            settle_q     <= '0;
            stim_q       <= '0;
            err_cnt_q    <= '0;
            first_fail_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        stim_q       <= '0;
                        err_cnt_q    <= '0;
                        first_fail_q <= '0;
                        pass_q       <= 1'b0;
                        busy_q       <= 1'b1;
                        fn_q         <= fn_t'(fn_sel);
                        settle_q     <= SETTLE_LOAD;
                        state_q      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_q == '0) begin
                        state_q <= CHECK;
                    end else begin
                        settle_q <= settle_q - CNT_ONE;
                    end
                end
                CHECK: begin
                    err_cnt_q <= err_cnt_d;
                    if (mismatch && (err_cnt_q == '0)) begin
                        first_fail_q <= stim_q;
                    end
                    if (&stim_q) begin
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_d == '0);
                        state_q <= DONE;
                    end else begin
                        stim_q   <= stim_q + STIM_ONE;
                        settle_q <= SETTLE_LOAD;
                        state_q  <= SETTLE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stim       = stim_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_cnt_q;
    assign first_fail = first_fail_q;

endmodule
